// File: rtl/dbus_req_ctrl_pkg.sv
// Shared data-bus types plus the request-controller state encoding and watchdog default.
package dbus_req_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DC_IDLE,
    DC_BUSY,
    DC_DRAIN
  } dbus_ctrl_state_t;

  localparam int unsigned DBUS_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/dbus_req_ctrl_timeout_cnt.sv
// Watchdog counter for outstanding dbus requests; hit marks the last permitted cycle.
module dbus_timeout_cnt
  import dbus_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = enable & (cnt_q == HIT_VAL);

endmodule

// File: rtl/dbus_req_ctrl.sv
// Memory-stage to dbus request controller: zero-latency issue, hold until data_ok, drain on kill.
// Optional watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_req_ctrl
  import dbus_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  m_req,
  input  logic       m_kill,
  output dbus_resp_t m_resp,
  output logic       m_stall,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       busy,
  output logic       timeout_err
);

  dbus_ctrl_state_t state_q, state_d;
  dbus_req_t        req_q, req_d;
  logic             to_hit;

`ifdef DBUS_TIMEOUT_EN
  logic to_err_q;

  dbus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == DC_IDLE),
    .enable(state_q != DC_IDLE),
    .hit   (to_hit)
  );

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DC_IDLE;
      req_q   <= '0;
`ifdef DBUS_TIMEOUT_EN
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
`ifdef DBUS_TIMEOUT_EN
      // A data_ok in the timeout cycle completes normally and raises no error.
      if (to_hit && !dresp.data_ok) begin
        to_err_q <= 1'b1;
      end
`endif
    end
  end

  // Outputs are gated while reset is high since IDLE forwards m_req combinationally.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dreq    = '0;
    m_resp  = '0;
    if (!reset) begin
      unique case (state_q)
        DC_IDLE: begin
          dreq       = m_req;
          dreq.valid = m_req.valid & ~m_kill;
          if (dreq.valid) begin
            if (dresp.data_ok) begin
              m_resp.data_ok = 1'b1;
              m_resp.data    = dresp.data;
            end else begin
              req_d   = m_req;
              state_d = DC_BUSY;
            end
          end
        end
        DC_BUSY: begin
          dreq       = req_q;
          dreq.valid = 1'b1;
          if (dresp.data_ok) begin
            if (!m_kill) begin
              m_resp.data_ok = 1'b1;
              m_resp.data    = dresp.data;
            end
            state_d = DC_IDLE;
          end else if (to_hit) begin
            // Dummy zero response unblocks the pipeline unless the instruction was squashed.
            m_resp.data_ok = ~m_kill;
            state_d        = DC_IDLE;
          end else if (m_kill) begin
            state_d = DC_DRAIN;
          end
        end
        DC_DRAIN: begin
          dreq       = req_q;
          dreq.valid = 1'b1;
          if (dresp.data_ok || to_hit) begin
            state_d = DC_IDLE;
          end
        end
        default: begin
          state_d = DC_IDLE;
        end
      endcase
    end
  end

  assign m_stall = m_req.valid & ~m_resp.data_ok;
  assign busy    = (state_q != DC_IDLE);

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Scoreboard bench for dbus_req_ctrl: transaction-level model drives expectations, negedge monitor checks.
module tb_dbus_req_ctrl;
  import dbus_req_ctrl_pkg::*;

  localparam int TB_TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  m_req, dreq;
  logic       m_kill;
  dbus_resp_t m_resp, dresp;
  logic       m_stall, busy, timeout_err;

  dbus_req_ctrl #(
    .TIMEOUT_CYCLES(TB_TO),
    .CNT_W         (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_kill     (m_kill),
    .m_resp     (m_resp),
    .m_stall    (m_stall),
    .dreq       (dreq),
    .dresp      (dresp),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  bit          chk_en = 0;
  bit          e_dvalid, e_resp, e_busy, e_stall, e_err, to_pending;
  dbus_req_t   e_dreq;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic dbus_req_t rand_req();
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = rnd64();
    r.size   = msize_t'($urandom_range(0, 3));
    r.strobe = 8'($urandom);
    r.data   = rnd64();
    return r;
  endfunction

  // Monitor: compares DUT against the per-cycle expectations and pops the response queue.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dreq_valid", 256'(dreq.valid), 256'(e_dvalid));
      if (e_dvalid) check("dreq", 256'(dreq), 256'(e_dreq));
      check("resp_ok", 256'(m_resp.data_ok), 256'(e_resp));
      check("busy", 256'(busy), 256'(e_busy));
      check("stall", 256'(m_stall), 256'(e_stall));
      check("timeout_err", 256'(timeout_err), 256'(e_err));
      if (m_resp.data_ok) begin
        if (exp_q.size() == 0) check("resp_unexpected", 256'(1), 256'(0));
        else check("resp_data", 256'(m_resp.data), 256'(exp_q.pop_front()));
      end else begin
        check("resp_data_zero", 256'(m_resp.data), 256'(0));
        if (e_resp && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (to_pending) begin
      e_err      = 1'b1;
      to_pending = 1'b0;
    end
  endtask

  task automatic gap();
    tick();
    m_req         = rand_req();
    m_req.valid   = 1'b0;
    m_kill        = 1'($urandom);
    dresp.data_ok = 1'($urandom);
    dresp.data    = rnd64();
    e_dvalid = 0; e_resp = 0; e_busy = 0; e_stall = 0;
    chk_en   = 1;
  endtask

  // One transaction: lat = cycles until bus data_ok (<0: never), kc = kill cycle (0: none).
  task automatic do_txn(input dbus_req_t r, input int lat, input int kc, input bit kill0);
    int last;
    tick();
    m_req         = r;
    m_kill        = kill0;
    dresp.data_ok = (lat == 0);
    dresp.data    = rnd64();
    e_dreq = r; e_busy = 0; e_resp = 0; e_dvalid = !kill0;
    if (!kill0 && lat == 0) begin
      e_resp = 1;
      exp_q.push_back(dresp.data);
    end
    e_stall = !e_resp;
    chk_en  = 1;
    if (kill0 || lat == 0) return;
    last = (lat < 0) ? TB_TO : lat;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (kc != 0 && kc < c) begin
        m_req       = rand_req();
        m_req.valid = 1'($urandom);
      end else begin
        m_req      = r;
        m_req.addr = r.addr ^ rnd64();
        m_req.data = rnd64();
      end
      m_kill        = (c == kc);
      dresp.data_ok = (c == lat);
      dresp.data    = rnd64();
      e_busy = 1; e_dvalid = 1; e_dreq = r;
      e_resp = (c == last) && (kc == 0);
      if (e_resp) exp_q.push_back((lat < 0) ? 64'd0 : dresp.data);
      if (lat < 0 && c == last) to_pending = 1;
      e_stall = m_req.valid && !e_resp;
    end
  endtask

  initial begin
    dbus_req_t r;
    int        lat, kc;
    bit        k0;
    reset = 1'b1; m_req = '0; m_kill = 0; dresp = '0;
    e_err = 0; to_pending = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_dvalid", 256'(dreq.valid), 256'(0));
    check("reset_err", 256'(timeout_err), 256'(0));

    r = rand_req(); r.addr = 64'h8000_0010; r.size = MSIZE8; r.strobe = 8'hFF;
    do_txn(r, 0, 0, 0);
    gap();
    r = rand_req(); r.addr = 64'h8000_0020; r.strobe = 8'h0F;
    do_txn(r, 3, 0, 0);
    do_txn(rand_req(), 4, 1, 0);
    do_txn(rand_req(), 2, 2, 0);
    gap();

    // Async reset between edges with a request outstanding.
    tick();
    chk_en = 0; m_req = rand_req(); m_kill = 0; dresp.data_ok = 0;
    tick();
    #2 reset = 1'b1; dresp.data_ok = 1'b1;
    #1;
    check("rst_mid_dvalid", 256'(dreq.valid), 256'(0));
    check("rst_mid_busy", 256'(busy), 256'(0));
    check("rst_mid_resp", 256'(m_resp.data_ok), 256'(0));
    @(posedge clk);
    #3 reset = 1'b0; dresp.data_ok = 0; m_req.valid = 0;
    e_err = 0; to_pending = 0;
    do_txn(rand_req(), 2, 0, 0);

`ifdef DBUS_TIMEOUT_EN
    do_txn(rand_req(), -1, 0, 0);
    gap();
    do_txn(rand_req(), 1, 0, 0);
    gap();
    #1 check("timeout_sticky", 256'(timeout_err), 256'(1));
`endif

    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(0, 5);
      k0  = ($urandom_range(0, 9) == 0);
      kc  = 0;
      if (lat > 0 && $urandom_range(0, 9) < 4) kc = $urandom_range(1, lat);
      do_txn(rand_req(), lat, kc, k0);
      if ($urandom_range(0, 3) == 0) gap();
    end
    gap();
    gap();
    @(posedge clk);
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
